// File: rtl/sincos_nco_if.sv
// sincos_nco_if: sample-strobe, control, ROM and output bundle of the
// quadrature NCO.
//   ce, sync, freq, phase   : sample strobe, restart and tuning words (to NCO)
//   cos_rom_a / sin_rom_a   : per-path quarter-wave ROM addresses (from NCO)
//   cos_rom_d / sin_rom_d   : {coarse, slope} ROM words, 2-cycle latency (to NCO)
//   cos_o, sin_o, valid     : signed quadrature outputs and sample strobe (from NCO)
// slave is the NCO side; master is the controller/ROM side.
interface sincos_nco_if #(
    parameter int NBF = 32,
    parameter int NBA = 22,
    parameter int NBR = 10,
    parameter int NBO = 18,
    parameter int NBM = 8
);
    logic                     ce;
    logic                     sync;
    logic [NBF-1:0]           freq;
    logic [NBA-1:0]           phase;
    logic [NBR-1:0]           cos_rom_a;
    logic [NBO+NBM-2:0]       cos_rom_d;
    logic [NBR-1:0]           sin_rom_a;
    logic [NBO+NBM-2:0]       sin_rom_d;
    logic signed [NBO-1:0]    cos_o;
    logic signed [NBO-1:0]    sin_o;
    logic                     valid;

    modport slave (
        input  ce, sync, freq, phase, cos_rom_d, sin_rom_d,
        output cos_rom_a, sin_rom_a, cos_o, sin_o, valid
    );

    modport master (
        output ce, sync, freq, phase, cos_rom_d, sin_rom_d,
        input  cos_rom_a, sin_rom_a, cos_o, sin_o, valid
    );
endinterface

// File: rtl/sincos_nco.sv
// sincos_nco: quadrature NCO. Phase accumulator plus phase offset drives two
// identical interpolated quarter-wave lookup paths (cos at angle, sin at
// angle - 90 degrees). One sample per ce; valid follows ce by 8 clocks.
//   c     : clock, rising edge
//   rn    : asynchronous active-low reset
//   bus   : sincos_nco_if.slave (ce/sync/freq/phase in, ROM ports, outputs)
module sincos_nco #(
    parameter int NBF = 32,
    parameter int NBA = 22,
    parameter int NBR = 10,
    parameter int NBO = 18,
    parameter int NBM = 8
) (
    input  logic         c,
    input  logic         rn,
    sincos_nco_if.slave  bus
);
    localparam int NBP = NBA - NBR - 2;
    localparam int NBD = NBO + NBM - 1;
    localparam int W   = NBO + NBP + NBM + 1;

    localparam logic [NBA-1:0]        QTR = NBA'(1) << (NBA - 2);
    localparam logic signed [W-1:0]   RND = W'(1) << (NBP - 1);

    logic [NBF-1:0] acc;
    logic [NBF-1:0] acc_used;
    logic [NBA-1:0] ang;
    logic [7:0]     vp;

    // per-path combinational angle decode (index 0 = cos, 1 = sin)
    logic [NBA-1:0] x    [2];
    logic [NBA-3:0] xa   [2];
    logic           neg  [2];
    logic [NBD-1:0] rd   [2];

    // per-path pipeline registers
    logic [NBR-1:0]          rom_a_r [2];
    logic [2:0]              neg_d   [2];
    logic [NBP-1:0]          frac_d  [2][3];
    logic signed [NBO:0]     c4      [2];
    logic signed [NBM-1:0]   sl4     [2];
    logic [NBP-1:0]          f4      [2];
    logic signed [W-1:0]     a5      [2];
    logic signed [NBM-1:0]   m5      [2];
    logic [NBP-1:0]          f5      [2];
    logic signed [W-1:0]     a6      [2];
    logic signed [W-1:0]     p6      [2];
    logic signed [W-1:0]     s7      [2];
    logic signed [NBO-1:0]   out_r   [2];
    logic                    valid_r;

    assign acc_used = bus.sync ? '0 : acc;
    assign rd[0]    = bus.cos_rom_d;
    assign rd[1]    = bus.sin_rom_d;

    always_comb begin
        x[0] = ang;
        x[1] = ang - QTR;
        for (int unsigned p = 0; p < 2; p++) begin
            neg[p] = x[p][NBA-1] ^ x[p][NBA-2];
            xa[p]  = x[p][NBA-2] ? ~x[p][NBA-3:0] : x[p][NBA-3:0];
        end
    end

    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            acc     <= '0;
            ang     <= '0;
            vp      <= '0;
            valid_r <= 1'b0;
            for (int unsigned p = 0; p < 2; p++) begin
                rom_a_r[p] <= '0;
                neg_d[p]   <= '0;
                for (int unsigned i = 0; i < 3; i++) frac_d[p][i] <= '0;
                c4[p]    <= '0;
                sl4[p]   <= '0;
                f4[p]    <= '0;
                a5[p]    <= '0;
                m5[p]    <= '0;
                f5[p]    <= '0;
                a6[p]    <= '0;
                p6[p]    <= '0;
                s7[p]    <= '0;
                out_r[p] <= '0;
            end
        end else begin
            if (bus.ce) begin
                acc <= acc_used + bus.freq;
                ang <= acc_used[NBF-1 -: NBA] + bus.phase;
            end
            vp      <= {vp[6:0], bus.ce};
            valid_r <= vp[7];
            for (int unsigned p = 0; p < 2; p++) begin
                // address stage; sign and fraction ride alongside the ROM latency
                rom_a_r[p]   <= xa[p][NBA-3 -: NBR];
                neg_d[p]     <= {neg_d[p][1:0], neg[p]};
                frac_d[p][0] <= xa[p][NBP-1:0];
                frac_d[p][1] <= frac_d[p][0];
                frac_d[p][2] <= frac_d[p][1];
                // sign apply: s*(coarse*2^NBP - frac*slope) = (s*coarse)*2^NBP - frac*(s*slope)
                c4[p]  <= neg_d[p][2] ? -(NBO+1)'(signed'(rd[p][NBD-1 -: NBO]))
                                      :  (NBO+1)'(signed'(rd[p][NBD-1 -: NBO]));
                sl4[p] <= neg_d[p][2] ? -signed'({1'b0, rd[p][NBM-2:0]})
                                      :  signed'({1'b0, rd[p][NBM-2:0]});
                f4[p]  <= frac_d[p][2];
                // multiply input register
                a5[p] <= W'(c4[p]) <<< NBP;
                m5[p] <= sl4[p];
                f5[p] <= f4[p];
                // multiply
                p6[p] <= W'(m5[p]) * W'(signed'({1'b0, f5[p]}));
                a6[p] <= a5[p];
                // add with rounding constant
                s7[p] <= a6[p] - p6[p] + RND;
                // arithmetic shift by NBP, keep low NBO bits; hold between samples
                if (vp[7]) out_r[p] <= s7[p][NBP +: NBO];
            end
        end
    end

    assign bus.cos_rom_a = rom_a_r[0];
    assign bus.sin_rom_a = rom_a_r[1];
    assign bus.cos_o     = out_r[0];
    assign bus.sin_o     = out_r[1];
    assign bus.valid     = valid_r;
endmodule

// File: tb/tb_sincos_nco.sv
module tb_sincos_nco;
    localparam int    A   = 80000;
    localparam real   PI  = 3.14159265358979323846;
    localparam longint M22 = 64'h3F_FFFF;
    localparam longint M32 = 64'hFFFF_FFFF;

    logic c;
    logic rn;

    sincos_nco_if #(.NBF(32), .NBA(22), .NBR(10), .NBO(18), .NBM(8)) bus ();

    sincos_nco #(.NBF(32), .NBA(22), .NBR(10), .NBO(18), .NBM(8)) dut (
        .c   (c),
        .rn  (rn),
        .bus (bus)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    // quarter-wave table shared by ROM model and reference
    int          coarse [1024];
    int          slope  [1024];
    logic [24:0] rom    [1024];
    logic [24:0] r1c, r2c, r1s, r2s;

    always @(posedge c) begin
        r1c <= rom[bus.cos_rom_a];
        r2c <= r1c;
        r1s <= rom[bus.sin_rom_a];
        r2s <= r1s;
    end
    assign bus.cos_rom_d = r2c;
    assign bus.sin_rom_d = r2s;

    int passed = 0;
    int total  = 0;

    // reference: value of one lookup path for angle a (22-bit)
    function automatic int gold(input longint a);
        longint q, lo, v;
        int     ad, fr, s;
        q  = (a >> 20) & 3;
        lo = a & 64'hF_FFFF;
        if (q == 1 || q == 3) lo = 64'hF_FFFF - lo;
        ad = int'(lo >> 10);
        fr = int'(lo & 1023);
        s  = (q == 0 || q == 3) ? 1 : -1;
        v  = longint'(s) * (longint'(coarse[ad]) * 1024 - longint'(fr) * slope[ad]) + 512;
        v  = v >>> 10;
        v  = v & 64'h3FFFF;
        if (v >= 64'h20000) v = v - 64'h40000;
        return int'(v);
    endfunction

    // model: accumulator and expected outputs keyed by the cycle they are due
    int     cyc = 0;
    longint acc = 0;
    int     ec [int];
    int     es [int];
    int     ce_cnt = 0;

    always @(posedge c) begin
        longint au, ang;
        cyc = cyc + 1;
        if (!rn) begin
            ec.delete();
            es.delete();
            acc = 0;
        end else if (bus.ce) begin
            au  = bus.sync ? 0 : acc;
            ang = ((au >> 10) + longint'(bus.phase)) & M22;
            ec[cyc + 8] = gold(ang);
            es[cyc + 8] = gold((ang + 3 * 64'h10_0000) & M22);
            acc = (au + longint'(bus.freq)) & M32;
            ce_cnt = ce_cnt + 1;
        end
    end

    // per-cycle compare against the model, plus capture of delivered samples
    int gc[$];
    int gs[$];
    int val_cnt = 0;
    int hc = 0, hs = 0;

    always @(negedge c) begin
        logic ev;
        int   xc, xs, ac, as_;
        if (!rn) begin
            ev = 1'b0; hc = 0; hs = 0;
        end else if (ec.exists(cyc)) begin
            ev = 1'b1; hc = ec[cyc]; hs = es[cyc];
        end else begin
            ev = 1'b0;
        end
        xc = hc; xs = hs;
        ac = bus.cos_o;
        as_ = bus.sin_o;
        total = total + 1;
        if (bus.valid === ev && ac == xc && as_ == xs && !$isunknown(bus.cos_o) && !$isunknown(bus.sin_o))
            passed = passed + 1;
        else
            $display("FAIL cycle%0d: valid=%b cos=%0d sin=%0d, expected valid=%b cos=%0d sin=%0d",
                     cyc, bus.valid, ac, as_, ev, xc, xs);
        if (bus.valid === 1'b1) begin
            gc.push_back(ac);
            gs.push_back(as_);
            val_cnt = val_cnt + 1;
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        total = total + 1;
        if (got == exp) passed = passed + 1;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic drive(input bit ce_i, input bit sync_i, input logic [31:0] f, input logic [21:0] p);
        @(posedge c);
        #1;
        bus.ce    = ce_i;
        bus.sync  = sync_i;
        bus.freq  = f;
        bus.phase = p;
    endtask

    task automatic wait_n(input int want);
        int guard;
        guard = 0;
        while (gc.size() < want && guard < 300) begin
            @(negedge c);
            guard++;
        end
        @(negedge c);
        if (gc.size() < want) chk("sample_timeout", gc.size(), want);
    endtask

    initial begin
        int b, mism, bad, ce0, v0, q0c, q1s, q2c;
        longint m2;

        for (int i = 0; i < 1024; i++)
            coarse[i] = $rtoi(A * $cos(i * PI / 2048.0) + 0.5);
        for (int i = 0; i < 1024; i++) begin
            slope[i] = coarse[i] - ((i == 1023) ? 0 : coarse[i + 1]);
            rom[i]   = {coarse[i][17:0], slope[i][6:0]};
        end

        bus.ce = 0; bus.sync = 0; bus.freq = '0; bus.phase = '0;
        rn = 1'b1;
        #1 rn = 1'b0;

        // reset state
        repeat (3) @(posedge c);
        #1;
        chk("rst_valid", bus.valid, 0);
        chk("rst_cos", bus.cos_o, 0);
        chk("rst_sin", bus.sin_o, 0);
        chk("rst_rom_a", {bus.cos_rom_a, bus.sin_rom_a}, 0);
        rn = 1'b1;
        repeat (3) drive(0, 0, 0, 0);

        // single sample, freq=0 phase=0
        b = gc.size();
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        wait_n(b + 1);
        chk("first_cos", gc[b], A);
        chk("first_sin", gs[b], 0);

        // continuous tone, 64-sample period
        b = gc.size();
        drive(1, 1, 32'h0400_0000, 0);
        repeat (255) drive(1, 0, 32'h0400_0000, 0);
        drive(0, 0, 0, 0);
        wait_n(b + 256);
        mism = 0; bad = 0;
        for (int n = 64; n < 256; n++)
            if (gc[b + n] != gc[b + n - 64] || gs[b + n] != gs[b + n - 64]) mism++;
        for (int n = 0; n < 256; n++) begin
            m2 = longint'(gc[b + n]) * gc[b + n] + longint'(gs[b + n]) * gs[b + n] - longint'(A) * A;
            if (m2 < 0) m2 = -m2;
            if (m2 * 1000 > longint'(A) * A) bad++;
        end
        chk("tone_period", mism, 0);
        chk("tone_magnitude", bad, 0);
        chk("tone_cos90", gc[b + 16], 0);
        chk("tone_sin90", gs[b + 16], A);
        chk("tone_cos180", gc[b + 32], -A);

        // quadrant symmetry, freq=0
        b = gc.size();
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 22'(i * 32'h10_0000));
        drive(0, 0, 0, 0);
        wait_n(b + 4);
        q0c = gc[b]; q1s = gs[b + 1]; q2c = gc[b + 2];
        chk("quad_cos0", q0c, A);
        chk("quad_cos180_sym", ((q2c + q0c) <= 1 && (q2c + q0c) >= -1) ? 1 : 0, 1);
        chk("quad_sin90_eq_cos0", q1s, q0c);
        chk("quad_sin270", gs[b + 3], -A);

        // negative step wrap and mid-stream sync
        b = gc.size();
        drive(1, 1, 32'hFFFF_FFFF, 0);
        repeat (5) drive(1, 0, 32'hFFFF_FFFF, 0);
        drive(1, 1, 32'hFFFF_FFFF, 0);
        drive(1, 0, 32'hFFFF_FFFF, 0);
        drive(0, 0, 0, 0);
        wait_n(b + 8);
        chk("wrap_cos1", gc[b + 1], A);
        chk("sync_cos", gc[b + 6], gc[b]);
        chk("sync_sin", gs[b + 6], gs[b]);
        chk("sync_next_cos", gc[b + 7], gc[b + 1]);
        chk("sync_next_sin", gs[b + 7], gs[b + 1]);

        // gapped random ce
        ce0 = ce_cnt; v0 = val_cnt;
        for (int i = 0; i < 500; i++)
            drive($urandom_range(0, 99) < 30, $urandom_range(0, 15) == 0, $urandom, 22'($urandom));
        repeat (12) drive(0, 0, 0, 0);
        chk("gapped_count", val_cnt - v0, ce_cnt - ce0);

        // reset mid-operation
        b = gc.size();
        drive(1, 0, 32'h0123_4567, 22'h12345);
        repeat (4) drive(1, 0, 32'h0123_4567, 22'h12345);
        @(posedge c); #1 bus.ce = 0;
        repeat (3) @(posedge c);
        #1 rn = 1'b0;
        #1;
        chk("midrst_valid", bus.valid, 0);
        chk("midrst_cos", bus.cos_o, 0);
        chk("midrst_sin", bus.sin_o, 0);
        repeat (3) @(posedge c);
        #1 rn = 1'b1;
        repeat (20) drive(0, 0, 0, 0);
        chk("midrst_no_stale", gc.size() - b, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sincos_nco.md
Name: sincos_nco

Overview:
- Parametrised quadrature NCO: phase accumulator, phase offset, and dual interpolated quarter-wave lookup producing sin and cos each sample.
- Successor to the single-output cosine interpolator. Adds accumulator, phase offset, sync/restart, valid pipeline, second output, and width generalisation.
- Sits between DDS control registers and the DSP datapath (mixers, DUC/DDC).
- Uses two external 2-cycle-latency ROM ports, one per output, with identical table contents.

Parameters:
- NBF, 32: phase accumulator / frequency word bits.
- NBA, 22: angle bits fed to lookup (top NBA of accumulator); NBA >= NBR+3.
- NBR, 10: ROM address bits (quarter-wave table depth 2^NBR).
- NBO, 18: output bits, signed.
- NBM, 8: slope field bits plus one (slope stored unsigned in NBM-1 bits).
- Derived: NBP = NBA-NBR-2, the interpolated fraction bits.

Ports:
- c  in  1  clock; all logic on rising edge.
- rn  in  1  reset, asynchronous, active-low.
- ce  in  1  sample strobe; one output sample per cycle ce=1.
- sync  in  1  with ce: restart accumulator at zero for this sample.
- freq  in  NBF  unsigned frequency word, sampled when ce=1.
- phase  in  NBA  unsigned phase offset, sampled when ce=1.
- cos_rom_a  out  NBR  cos-path ROM address.
- cos_rom_d  in  NBO+NBM-1  {coarse[NBO-1:0], slope[NBM-2:0]}, registered ROM, data 2 clocks after address.
- sin_rom_a  out  NBR  sin-path ROM address.
- sin_rom_d  in  NBO+NBM-1  same format/latency as cos_rom_d.
- cos_o  out  NBO  signed cosine.
- sin_o  out  NBO  signed sine.
- valid  out  1  cos_o/sin_o carry a new sample.

Behaviour:
- Reset (rn=0, async): accumulator, every pipeline register, cos_o, sin_o and valid all clear to 0. ROM address outputs then decode to 0.
- On release, no valid until a ce arrives plus the full latency.
  - Reset mid-operation discards all in-flight samples; no stale valid may follow.
- Accumulator, when ce=1:
  - Sample angle uses the pre-update accumulator acc, or 0 if sync=1.
  - acc <= (sync ? 0 : acc) + freq, mod 2^NBF, wrapping silently.
  - When ce=0, acc holds and no sample is issued.
- Angle register: ang <= acc_used[NBF-1 -: NBA] + phase, mod 2^NBA.
  - Cos path angle = ang.
  - Sin path angle = ang - 2^(NBA-2), mod 2^NBA.
- Per path (identical logic), for angle x:
  - q = x[NBA-1:NBA-2]
  - s = +1 if q[1]^q[0]=0, else -1
  - x_adj = q[0] ? ~x[NBA-3:0] : x[NBA-3:0]
  - rom_a = x_adj[NBA-3 -: NBR]
  - frac = x_adj[NBP-1:0]
  - out = floor( (s*(coarse*2^NBP - frac*slope) + 2^(NBP-1)) / 2^NBP ), taken as low NBO bits in two's complement.
  - The product is full width; there is no saturation, and the ROM guarantees range.
- Pipeline: fixed, free-running, no back-pressure. Stages:
  - acc/ang register
  - 2 ROM stages (sign, frac, x_adj delayed alongside)
  - sign apply
  - multiply input register
  - multiply
  - add/output register
- Latency: ce sampled high at edge k gives valid=1 with the corresponding cos_o/sin_o after edge k+8, for exactly one cycle per ce.
- Back-to-back ce: one sample per cycle, valid continuous.
- Between samples: cos_o/sin_o hold their last value while valid=0.
- Simultaneous sync and freq change: the new freq applies and is added to 0.
- sin and cos of the same sample always appear in the same cycle.

Test Plan:
- Reset/latency: hold rn=0, release, pulse ce once with freq=0, phase=0 at edge k. Require:
  - valid=0 through edge k+7
  - valid=1 only after edge k+8
  - cos_o = coarse[0] (frac=0)
  - sin_o matches golden model
- Continuous tone: ce=1 constant, freq=2^(NBF-6), 256 samples vs bit-exact golden model using the same ROM table.
  - Require zero mismatches.
  - Require a 64-sample period, with cos_o^2+sin_o^2 within 0.1% of full scale.
- Quadrant symmetry: phase in {0, 2^(NBA-2), 2^(NBA-1), 3*2^(NBA-2)}, freq=0.
  - Require cos_o at phase 2^(NBA-1) = -cos_o at phase 0, ±1 LSB.
  - Require sin_o at phase 2^(NBA-2) = cos_o at phase 0.
- Wrap/sync: freq=2^NBF-1 (negative step), check the accumulator wraps.
  - Assert sync with ce mid-stream: that sample equals the phase-only sample.
  - The next sample equals the phase+freq sample.
- Gapped ce: random 30% ce duty over 500 cycles.
  - valid count equals ce count.
  - Each valid lands 8 cycles after its ce.
  - Outputs hold between valids.
- Reset mid-operation: assert rn low 3 cycles after a ce burst of 5.
  - Require valid, cos_o and sin_o = 0 immediately (async).
  - No valid ever appears for the discarded samples.
